vending_machine: RTL and testbench

VENDING_MACHINE -- requirements
Module: vending_machine

---
 rtl/vm_pkg.sv | 25 ++
 rtl/vm_inventory.sv | 41 ++++
 rtl/vending_machine.sv | 124 ++++++++++++
 tb/tb_vending_machine.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared encodings, widths and the price table for the vending machine.
package vm_pkg;

    localparam int unsigned MONEY_W      = 4;
    localparam int unsigned STOCK_W      = 4;
    localparam int unsigned QTY_W        = 4;
    localparam int unsigned ID_W         = 3;
    localparam int unsigned COST_W       = 8;
    localparam int unsigned NUM_PRODUCTS = 8;
    localparam int unsigned MONEY_MAX    = 15;
    localparam int unsigned STOCK_MAX    = 15;

    typedef enum logic [1:0] {
        MODE_PURCHASE = 2'b00,
        MODE_WITHDRAW = 2'b01,
        MODE_SUPPLY   = 2'b10,
        MODE_ILLEGAL  = 2'b11
    } vm_mode_e;

    // Entry i (LSB first) holds (i mod 4) + 1.
    localparam logic [NUM_PRODUCTS-1:0][COST_W-1:0] PRICE = {
        8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1
    };

endpackage

// File: rtl/vm_inventory.sv
// Per-product stock storage: two combinational read ports, one write port.
module vm_inventory
    import vm_pkg::*;
#(
    parameter int unsigned INIT_STOCK = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ID_W-1:0]    rd_id_a,
    output logic [STOCK_W-1:0] rd_data_a_c,
    input  logic [ID_W-1:0]    rd_id_b,
    output logic [STOCK_W-1:0] rd_data_b_c,
    input  logic               wr_en,
    input  logic [ID_W-1:0]    wr_id,
    input  logic [STOCK_W-1:0] wr_data
);

    logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];

    always_comb begin
        stock_d = stock_q;
        if (wr_en) begin
            stock_d[wr_id] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            stock_q <= stock_d;
        end
    end

    assign rd_data_a_c = stock_q[rd_id_a];
    assign rd_data_b_c = stock_q[rd_id_b];

endmodule

// File: rtl/vending_machine.sv
// Vending machine: purchase / withdraw / supply decode and money bookkeeping.
// Optional VM_OVERFLOW_GUARD_EN rejects purchases that would overflow machine_money.
module vending_machine
    import vm_pkg::*;
#(
    parameter int unsigned INIT_STOCK = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         mode,
    input  logic [MONEY_W-1:0] customer_money,
    input  logic [ID_W-1:0]    customer_request,
    input  logic [QTY_W-1:0]   quantity_request,
    input  logic [ID_W-1:0]    product_id,
    input  logic [STOCK_W-1:0] amount_added,
    output logic               red_light,
    output logic [MONEY_W-1:0] updated_customer_money,
    output logic [MONEY_W-1:0] machine_money,
    output logic [STOCK_W-1:0] stock_level
);

    logic               red_q, red_d;
    logic [MONEY_W-1:0] upd_money_q, upd_money_d;
    logic [MONEY_W-1:0] mach_money_q, mach_money_d;

    logic [STOCK_W-1:0] req_stock_c;
    logic [COST_W-1:0]  cost_c;
    logic [COST_W-1:0]  money_sum_c;
    logic [STOCK_W:0]   supply_sum_c;
    logic               purchase_reject_c;
    logic               wr_en;
    logic [ID_W-1:0]    wr_id;
    logic [STOCK_W-1:0] wr_data;

    vm_inventory #(
        .INIT_STOCK (INIT_STOCK)
    ) u_inventory (
        .clk         (clk),
        .rst         (rst),
        .rd_id_a     (customer_request),
        .rd_data_a_c (req_stock_c),
        .rd_id_b     (product_id),
        .rd_data_b_c (stock_level),
        .wr_en       (wr_en),
        .wr_id       (wr_id),
        .wr_data     (wr_data)
    );

    // Full-width cost so large quantities cannot wrap into an affordable price.
    assign cost_c       = PRICE[customer_request] * COST_W'(quantity_request);
    assign money_sum_c  = COST_W'(mach_money_q) + cost_c;
    assign supply_sum_c = (STOCK_W + 1)'(stock_level) + (STOCK_W + 1)'(amount_added);

`ifdef VM_OVERFLOW_GUARD_EN
    assign purchase_reject_c = (quantity_request == '0)
                            || (req_stock_c < quantity_request)
                            || (COST_W'(customer_money) < cost_c)
                            || (money_sum_c > COST_W'(MONEY_MAX));
`else
    assign purchase_reject_c = (quantity_request == '0)
                            || (req_stock_c < quantity_request)
                            || (COST_W'(customer_money) < cost_c);
`endif

    always_comb begin
        red_d        = red_q;
        upd_money_d  = upd_money_q;
        mach_money_d = mach_money_q;
        wr_en        = 1'b0;
        wr_id        = product_id;
        wr_data      = supply_sum_c[STOCK_W-1:0];
        if (op_valid) begin
            case (vm_mode_e'(mode))
                MODE_PURCHASE: begin
                    if (purchase_reject_c) begin
                        red_d       = 1'b1;
                        upd_money_d = customer_money;
                    end else begin
                        red_d        = 1'b0;
                        upd_money_d  = customer_money - MONEY_W'(cost_c);
                        mach_money_d = (money_sum_c > COST_W'(MONEY_MAX))
                                       ? MONEY_W'(MONEY_MAX) : MONEY_W'(money_sum_c);
                        wr_en        = 1'b1;
                        wr_id        = customer_request;
                        wr_data      = req_stock_c - quantity_request;
                    end
                end
                MODE_WITHDRAW: begin
                    red_d        = (mach_money_q == '0);
                    mach_money_d = '0;
                end
                MODE_SUPPLY: begin
                    if (supply_sum_c > (STOCK_W + 1)'(STOCK_MAX)) begin
                        red_d = 1'b1;
                    end else begin
                        red_d = 1'b0;
                        wr_en = 1'b1;
                    end
                end
                default: begin
                    red_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_q        <= 1'b0;
            upd_money_q  <= '0;
            mach_money_q <= '0;
        end else begin
            red_q        <= red_d;
            upd_money_q  <= upd_money_d;
            mach_money_q <= mach_money_d;
        end
    end

    assign red_light              = red_q;
    assign updated_customer_money = upd_money_q;
    assign machine_money          = mach_money_q;

endmodule

// File: tb/tb_vending_machine.sv
// Table-driven bench for vending_machine; expectations follow VM_OVERFLOW_GUARD_EN.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [1:0] mode;
    logic [3:0] customer_money;
    logic [2:0] customer_request;
    logic [3:0] quantity_request;
    logic [2:0] product_id;
    logic [3:0] amount_added;
    logic       red_light;
    logic [3:0] updated_customer_money;
    logic [3:0] machine_money;
    logic [3:0] stock_level;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] M_BUY = 2'b00, M_WD = 2'b01, M_SUP = 2'b10, M_BAD = 2'b11;

`ifdef VM_OVERFLOW_GUARD_EN
    localparam int G6_RED = 1, G6_UPD = 4, G6_MM = 12, G_ST3 = 5;
    localparam int G16_RED = 1, G16_UPD = 2, G16_MM = 14, G16_ST5 = 5;
`else
    localparam int G6_RED = 0, G6_UPD = 0, G6_MM = 15, G_ST3 = 4;
    localparam int G16_RED = 0, G16_UPD = 0, G16_MM = 15, G16_ST5 = 4;
`endif

    typedef struct {
        bit         rst;
        bit         ov;
        logic [1:0] mode;
        logic [3:0] money;
        logic [2:0] req;
        logic [3:0] qty;
        logic [2:0] pid;
        logic [3:0] amt;
        bit         e_red;
        logic [3:0] e_upd;
        logic [3:0] e_mm;
        logic [3:0] e_stk;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    vending_machine #(.INIT_STOCK(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .op_valid               (op_valid),
        .mode                   (mode),
        .customer_money         (customer_money),
        .customer_request       (customer_request),
        .quantity_request       (quantity_request),
        .product_id             (product_id),
        .amount_added           (amount_added),
        .red_light              (red_light),
        .updated_customer_money (updated_customer_money),
        .machine_money          (machine_money),
        .stock_level            (stock_level)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit ov, logic [1:0] m, int money, int req, int qty,
                                int pid, int amt, int red, int upd, int mm, int stk);
        vec_t v;
        v.rst = r; v.ov = ov; v.mode = m;
        v.money = 4'(money); v.req = 3'(req); v.qty = 4'(qty);
        v.pid = 3'(pid); v.amt = 4'(amt);
        v.e_red = red[0]; v.e_upd = 4'(upd); v.e_mm = 4'(mm); v.e_stk = 4'(stk);
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit ov, input logic [1:0] m, input int money,
                         input int req, input int qty, input int pid, input int amt);
        rst = r; op_valid = ov; mode = m;
        customer_money = 4'(money); customer_request = 3'(req);
        quantity_request = 4'(qty); product_id = 3'(pid); amount_added = 4'(amt);
    endtask

    task automatic check_outs(input string tag, input int red, input int upd, input int mm,
                              input int stk);
        check({tag, ".red_light"}, int'(red_light), red);
        check({tag, ".change"}, int'(updated_customer_money), upd);
        check({tag, ".machine_money"}, int'(machine_money), mm);
        check({tag, ".stock_level"}, int'(stock_level), stk);
    endtask

    // One clock: inputs applied at the falling edge, results sampled 1ns after the rising edge.
    task automatic step(input bit r, input bit ov, input logic [1:0] m, input int money,
                        input int req, input int qty, input int pid, input int amt);
        drive(r, ov, m, money, req, qty, pid, amt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, M_BUY, 9, 2, 2, 2, 0,  0, 0, 0, 5);
        vecs[1]  = mk(0, 1, M_BUY, 9, 2, 2, 2, 0,  0, 3, 6, 3);
        vecs[2]  = mk(0, 1, M_BUY, 5, 3, 3, 3, 0,  1, 5, 6, 5);
        vecs[3]  = mk(0, 1, M_BUY, 15, 0, 6, 0, 0, 1, 15, 6, 5);
        vecs[4]  = mk(0, 1, M_SUP, 15, 0, 6, 0, 4, 0, 15, 6, 9);
        vecs[5]  = mk(0, 1, M_BUY, 6, 0, 6, 0, 0,  0, 0, 12, 3);
        vecs[6]  = mk(0, 1, M_BUY, 4, 3, 1, 3, 0,  G6_RED, G6_UPD, G6_MM, G_ST3);
        vecs[7]  = mk(0, 1, M_WD, 0, 0, 0, 3, 0,   0, G6_UPD, 0, G_ST3);
        vecs[8]  = mk(0, 1, M_WD, 0, 0, 0, 3, 0,   1, G6_UPD, 0, G_ST3);
        vecs[9]  = mk(0, 1, M_SUP, 0, 0, 0, 1, 11, 1, G6_UPD, 0, 5);
        vecs[10] = mk(0, 1, M_BAD, 9, 1, 1, 1, 3,  1, G6_UPD, 0, 5);
        vecs[11] = mk(0, 0, M_BUY, 15, 1, 1, 1, 3, 1, G6_UPD, 0, 5);
        vecs[12] = mk(0, 0, M_SUP, 15, 1, 1, 1, 3, 1, G6_UPD, 0, 5);
        vecs[13] = mk(0, 0, M_WD, 15, 1, 1, 1, 3,  1, G6_UPD, 0, 5);
        vecs[14] = mk(0, 1, M_BUY, 5, 1, 0, 1, 0,  1, 5, 0, 5);
        vecs[15] = mk(0, 1, M_SUP, 5, 1, 0, 1, 0,  0, 5, 0, 5);
        vecs[16] = mk(0, 1, M_SUP, 5, 1, 0, 1, 10, 0, 5, 0, 15);
        vecs[17] = mk(0, 1, M_BUY, 15, 1, 7, 1, 0, 0, 1, 14, 8);
        vecs[18] = mk(0, 1, M_BUY, 2, 5, 1, 5, 0,  G16_RED, G16_UPD, G16_MM, G16_ST5);
        vecs[19] = mk(1, 1, M_BUY, 2, 5, 1, 5, 0,  0, 0, 0, 5);
        vecs[20] = mk(0, 1, M_BUY, 15, 3, 15, 3, 0, 1, 15, 0, 5);
        vecs[21] = mk(0, 1, M_SUP, 15, 3, 0, 3, 10, 0, 15, 0, 15);

        drive(1, 0, M_BUY, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, M_BUY, 0, 0, 0, 0, 0);
        #1;
        check_outs("reset", 0, 0, 0, 5);
        for (int id = 0; id < 8; id++) begin
            product_id = 3'(id);
            #1;
            check($sformatf("reset.stock[%0d]", id), int'(stock_level), 5);
        end

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].ov, vecs[i].mode, int'(vecs[i].money), int'(vecs[i].req),
                 int'(vecs[i].qty), int'(vecs[i].pid), int'(vecs[i].amt));
            check_outs($sformatf("vec%0d", i), int'(vecs[i].e_red), int'(vecs[i].e_upd),
                       int'(vecs[i].e_mm), int'(vecs[i].e_stk));
            @(negedge clk);
        end

        // Withdraw from exactly 6, then withdraw from empty, then idle three clocks.
        step(1, 0, M_BUY, 0, 0, 0, 2, 0);
        @(negedge clk);
        step(0, 1, M_BUY, 9, 2, 2, 2, 0);
        check_outs("seq.buy", 0, 3, 6, 3);
        @(negedge clk);
        step(0, 1, M_WD, 0, 0, 0, 2, 0);
        check_outs("seq.wd1", 0, 3, 0, 3);
        @(negedge clk);
        step(0, 1, M_WD, 0, 0, 0, 2, 0);
        check_outs("seq.wd2", 1, 3, 0, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step(0, 0, M_SUP, 9, 2, 1, 2, 4);
            check_outs($sformatf("seq.idle%0d", k), 1, 3, 0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
